// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter: FSM state encoding,
// header tag and the round-robin pick function.
package uart_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam logic [3:0]  HDR_TAG = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    HDR,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  // First valid index found searching ptr+1, ptr+2, ... modulo n; ptr if none valid.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if ((k <= n) && !found && valid[3'(idx)]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational winner selection rotated after the last
// winner, with the last-winner pointer held in a register.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_valid,
  input  logic             update,
  output logic [ID_W-1:0]  winner_c,
  output logic             any_c
);

  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] rr_ptr_d;

  assign any_c    = |req_valid;
  assign winner_c = ID_W'(rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr_q), N_REQ));

  // Pointer moves to the winner only when the grant is actually taken.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (update) rr_ptr_d = winner_c;
  end

  // Pointer register; reset makes requester 0 the first to be searched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr_q <= ID_W'(N_REQ - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART TX core among N_REQ byte
// streams. Optional feature: define UART_TX_ARB_HDR_EN to prefix every packet
// with a header byte {4'hA, 1'b0, grant_id[2:0]}.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned MAX_PKT_LEN = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][7:0]       req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id,
  output logic                        grant_active,
  output logic                        pkt_trunc
);

  localparam int unsigned ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W   = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_LEN);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic            grant_active_q, grant_active_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            last_q, last_d;
  logic            hdr_q, hdr_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic            tx_start_q, tx_start_d;
  logic            pkt_trunc_q, pkt_trunc_d;

  logic            arb_update;
  logic [ID_W-1:0] winner;
  logic            any_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .update    (arb_update),
    .winner_c  (winner),
    .any_c     (any_valid)
  );

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign grant_id     = grant_id_q;
  assign grant_active = grant_active_q;
  assign pkt_trunc    = pkt_trunc_q;

  // Next-state and output decode; tx_start/pkt_trunc are computed one cycle ahead.
  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    tx_data_d      = tx_data_q;
    last_d         = last_q;
    hdr_d          = hdr_q;
    byte_cnt_d     = byte_cnt_q;
    tx_start_d     = 1'b0;
    pkt_trunc_d    = 1'b0;
    arb_update     = 1'b0;
    req_ready      = '0;
    case (state_q)
      IDLE: begin
        if (any_valid) state_d = GRANT;
      end
      GRANT: begin
        // Requests may have vanished since IDLE; fall back without a grant.
        if (any_valid) begin
          arb_update     = 1'b1;
          grant_id_d     = winner;
          grant_active_d = 1'b1;
          byte_cnt_d     = '0;
`ifdef UART_TX_ARB_HDR_EN
          state_d        = HDR;
`else
          state_d        = LOAD;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef UART_TX_ARB_HDR_EN
      HDR: begin
        tx_data_d  = {HDR_TAG, 1'b0, 3'(grant_id_q)};
        last_d     = 1'b0;
        hdr_d      = 1'b1;
        tx_start_d = 1'b1;
        state_d    = START;
      end
`endif
      LOAD: begin
        if (req_valid[grant_id_q]) begin
          req_ready[grant_id_q] = 1'b1;
          tx_data_d  = req_data[grant_id_q];
          last_d     = req_last[grant_id_q];
          hdr_d      = 1'b0;
          tx_start_d = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        if (!hdr_q && (byte_cnt_q != MAX_CNT)) byte_cnt_d = byte_cnt_q + CNT_W'(1);
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = LOAD;
          end else if (last_q || (byte_cnt_q == MAX_CNT)) begin
            grant_active_d = 1'b0;
            pkt_trunc_d    = !last_q;
            state_d        = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      tx_data_q      <= '0;
      last_q         <= 1'b0;
      hdr_q          <= 1'b0;
      byte_cnt_q     <= '0;
      tx_start_q     <= 1'b0;
      pkt_trunc_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      tx_data_q      <= tx_data_d;
      last_q         <= last_d;
      hdr_q          <= hdr_d;
      byte_cnt_q     <= byte_cnt_d;
      tx_start_q     <= tx_start_d;
      pkt_trunc_q    <= pkt_trunc_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART TX core
// (tx_busy high for 10 cycles after each tx_start).
module tb_uart_tx_arbiter;

  localparam int unsigned N_REQ       = 4;
  localparam int unsigned MAX_PKT_LEN = 64;
  localparam int unsigned ID_W        = 2;
`ifdef UART_TX_ARB_HDR_EN
  localparam int HDR_N = 1;
`else
  localparam int HDR_N = 0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0][7:0] req_data;
  logic [N_REQ-1:0]      req_last;
  logic [N_REQ-1:0]      req_ready;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_busy;
  logic [ID_W-1:0]       grant_id;
  logic                  grant_active;
  logic                  pkt_trunc;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_starts = 0;
  int trunc_cnt = 0;
  logic [8:0] drv_q [N_REQ][$];
  logic [7:0] sb_q  [N_REQ][$];
  logic [N_REQ-1:0] pause = '0;
  int grant_log[$];
  int bytes_log[$];

  uart_tx_arbiter #(
    .N_REQ       (N_REQ),
    .MAX_PKT_LEN (MAX_PKT_LEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .pkt_trunc    (pkt_trunc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_byte(input int id, input logic [7:0] b, input logic last);
    drv_q[id].push_back({last, b});
    sb_q[id].push_back(b);
  endtask

  task automatic push_pkt(input int id, input int n, input logic last_at_end);
    for (int k = 0; k < n; k++)
      push_byte(id, 8'($urandom), last_at_end && (k == n - 1));
  endtask

  function automatic bit drv_empty();
    bit e = 1'b1;
    for (int i = 0; i < N_REQ; i++) if (drv_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  function automatic int sb_total();
    int t = 0;
    for (int i = 0; i < N_REQ; i++) t += sb_q[i].size();
    return t;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int  c = 0;
    bit  done = 1'b0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
      done = drv_empty() && !grant_active && !tx_busy;
    end
    repeat (3) @(negedge clk);
    check_eq({tag, "_idle"}, 32'(done), 1);
    check_eq({tag, "_sb_left"}, sb_total(), 0);
  endtask

  task automatic wait_grant(input string tag, input int budget);
    int c = 0;
    while (!grant_active && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq({tag, "_granted"}, 32'(grant_active), 1);
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    int c = 0;
    while (tx_starts < target && c < budget) begin
      @(negedge clk);
      #2;
      c++;
    end
    check_eq({tag, "_starts"}, tx_starts, target);
  endtask

  task automatic check_seq(input string tag, input int n, input int ids[4], input int lens[4]);
    check_eq({tag, "_ngrants"}, grant_log.size(), n);
    check_eq({tag, "_nlens"}, bytes_log.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < grant_log.size()) check_eq($sformatf("%s_id%0d", tag, k), grant_log[k], ids[k]);
      if (k < bytes_log.size()) check_eq($sformatf("%s_len%0d", tag, k), bytes_log[k], lens[k]);
    end
    grant_log.delete();
    bytes_log.delete();
  endtask

  // Requester drivers: present queue heads at negedge, pop on handshake before posedge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (reset && !pause[i] && drv_q[i].size() != 0) begin
          req_valid[i] = 1'b1;
          req_data[i]  = drv_q[i][0][7:0];
          req_last[i]  = drv_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[i]  = '0;
          req_last[i]  = 1'b0;
        end
      end
      #4;
      for (int i = 0; i < N_REQ; i++)
        if (req_valid[i] && req_ready[i]) void'(drv_q[i].pop_front());
    end
  end

  // Behavioural UART TX core.
  initial begin
    int busy_cnt;
    bit start_seen;
    busy_cnt = 0;
    tx_busy  = 1'b0;
    forever begin
      @(negedge clk);
      start_seen = tx_start;
      @(posedge clk);
      #1;
      if (start_seen) busy_cnt = 10;
      else if (busy_cnt != 0) busy_cnt--;
      tx_busy = (busy_cnt != 0);
    end
  end

  // Output monitor and scoreboard comparison.
  initial begin
    bit prev_active, prev_start, prev_accept, hdr_pending;
    int gbytes;
    logic [ID_W-1:0] cur_id;
    logic [7:0] exp_b;
    prev_active = 0; prev_start = 0; prev_accept = 0; hdr_pending = 0;
    gbytes = 0; cur_id = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        prev_active = 0; prev_start = 0; prev_accept = 0; hdr_pending = 0;
      end else begin
        if (prev_accept) check_eq("start_latency", 32'(tx_start), 1);
        if (req_ready != '0)
          check_eq("ready_owner", 32'(req_ready), grant_active ? (32'd1 << grant_id) : 32'd0);
        if (grant_active && !prev_active) begin
          grant_log.push_back(int'(grant_id));
          gbytes      = 0;
          cur_id      = grant_id;
          hdr_pending = (HDR_N != 0);
        end
        if (tx_start) begin
          tx_starts++;
          check_eq("start_pulse", 32'(prev_start), 0);
          check_eq("owner_fixed", 32'(grant_id), 32'(cur_id));
          if (hdr_pending) begin
            hdr_pending = 0;
            check_eq("hdr_byte", 32'(tx_data), {24'd0, 4'hA, 1'b0, 3'(cur_id)});
          end else begin
            gbytes++;
            check_eq("sb_pending", 32'(sb_q[grant_id].size() != 0), 1);
            if (sb_q[grant_id].size() != 0) begin
              exp_b = sb_q[grant_id].pop_front();
              check_eq("tx_data", 32'(tx_data), 32'(exp_b));
            end
          end
        end
        if (pkt_trunc) begin
          trunc_cnt++;
          check_eq("trunc_len", gbytes, MAX_PKT_LEN);
        end
        if (!grant_active && prev_active) bytes_log.push_back(gbytes);
        prev_active = grant_active;
        prev_start  = tx_start;
        prev_accept = |(req_valid & req_ready);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, tbase, at_rst;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_tx_start", 32'(tx_start), 0);
    check_eq("rst_grant_active", 32'(grant_active), 0);
    check_eq("rst_grant_id", 32'(grant_id), 0);
    check_eq("rst_pkt_trunc", 32'(pkt_trunc), 0);
    check_eq("rst_tx_data", 32'(tx_data), 0);
    check_eq("rst_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    reset = 1'b1;

    // 1: single two-byte packet from requester 0
    base = tx_starts;
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b1);
    wait_idle("s1", 500);
    check_eq("s1_nstart", tx_starts - base, 2 + HDR_N);
    check_seq("s1", 1, '{0, 0, 0, 0}, '{2, 0, 0, 0});

    // 2: two simultaneous requesters served whole-packet in rotation order
    push_pkt(1, 3, 1'b1);
    push_pkt(2, 2, 1'b1);
    wait_idle("s2", 1000);
    check_seq("s2", 2, '{1, 2, 0, 0}, '{3, 2, 0, 0});

    // 3: waiting requester 3 is served between back-to-back packets of 0
    push_pkt(0, 2, 1'b1);
    push_pkt(0, 2, 1'b1);
    push_pkt(0, 2, 1'b1);
    wait_grant("s3", 50);
    push_pkt(3, 2, 1'b1);
    wait_idle("s3", 2000);
    check_seq("s3", 4, '{0, 3, 0, 0}, '{2, 2, 2, 2});

    // 4: 70-byte stream truncated at 64, another requester slips in between
    tbase = trunc_cnt;
    push_pkt(2, 69, 1'b0);
    push_byte(2, 8'($urandom), 1'b1);
    wait_grant("s4", 50);
    push_pkt(0, 1, 1'b1);
    wait_idle("s4", 4000);
    check_eq("s4_truncs", trunc_cnt - tbase, 1);
    check_seq("s4", 3, '{2, 0, 2, 0}, '{64, 1, 6, 0});

    // 5: granted requester stalls; grant is held and the other stays blocked
    base = tx_starts;
    push_pkt(0, 4, 1'b1);
    wait_starts("s5a", base + HDR_N + 2, 300);
    pause[0] = 1'b1;
    push_pkt(1, 2, 1'b1);
    repeat (35) @(negedge clk);
    #2;
    check_eq("s5_stall_starts", tx_starts - base, HDR_N + 2);
    check_eq("s5_hold_active", 32'(grant_active), 1);
    check_eq("s5_hold_id", 32'(grant_id), 0);
    pause[0] = 1'b0;
    wait_idle("s5", 1000);
    check_seq("s5", 2, '{0, 1, 0, 0}, '{4, 2, 0, 0});

    // 6: reset in the middle of a packet, then fresh arbitration
    base = tx_starts;
    push_pkt(0, 3, 1'b1);
    wait_starts("s6a", base + HDR_N + 1, 300);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("s6_rst_active", 32'(grant_active), 0);
    check_eq("s6_rst_start", 32'(tx_start), 0);
    check_eq("s6_rst_id", 32'(grant_id), 0);
    check_eq("s6_rst_data", 32'(tx_data), 0);
    check_eq("s6_rst_trunc", 32'(pkt_trunc), 0);
    check_eq("s6_rst_ready", 32'(req_ready), 0);
    for (int i = 0; i < N_REQ; i++) begin
      drv_q[i].delete();
      sb_q[i].delete();
    end
    at_rst = tx_starts;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    grant_log.delete();
    bytes_log.delete();
    repeat (4) @(negedge clk);
    #2;
    check_eq("s6_idle_active", 32'(grant_active), 0);
    check_eq("s6_no_start", tx_starts - at_rst, 0);
    wait_idle("s6q", 100);
    push_pkt(1, 2, 1'b1);
    push_pkt(0, 2, 1'b1);
    wait_idle("s6", 1000);
    check_seq("s6", 2, '{0, 1, 0, 0}, '{2, 2, 0, 0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
